// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module : fetch_queue_pkg
// Brief  : Shared processor constants and entry type for the fetch queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int          c_fq_depth     = 4;
    localparam logic [31:0] c_fq_nop_instr = 32'h00000000;
    localparam int          c_fq_entry_w   = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module : fetch_queue_if
// Brief  : Fetch-to-decode handshake bundle carried through the fetch queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_fq_depth
);
    logic [31:0]              InPC;
    logic [31:0]              InInstr;
    logic                     InValid;
    logic                     PCWrite;
    logic                     Flush;
    logic                     DecodeStall;
    logic                     OutValid;
    logic [31:0]              OutPC;
    logic [31:0]              OutInstr;
    logic [31:0]              OutPCPlus4;
    logic [$clog2(DEPTH):0]   Count;

    modport master (
        output InPC, InInstr, InValid, Flush, DecodeStall,
        input  PCWrite, OutValid, OutPC, OutInstr, OutPCPlus4, Count
    );

    modport slave (
        input  InPC, InInstr, InValid, Flush, DecodeStall,
        output PCWrite, OutValid, OutPC, OutInstr, OutPCPlus4, Count
    );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_ram.sv
// ============================================================================
// Module : fetch_queue_ram
// Brief  : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_fq_depth,
    parameter int WIDTH = c_fq_entry_w
) (
    input  wire logic                      Clk,
    input  wire logic                      i_we,
    input  wire logic [$clog2(DEPTH)-1:0]  i_waddr,
    input  wire logic [WIDTH-1:0]          i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0]  i_raddr,
    output logic      [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Circular instruction queue between fetch and decode, no bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = c_fq_depth,
    parameter logic [31:0] NOP_INSTR = c_fq_nop_instr
) (
    input  wire logic   Clk,
    input  wire logic   Reset,
    fetch_queue_if.slave fq
);

    localparam int                  c_ptr_w = $clog2(DEPTH);
    localparam int                  c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(DEPTH);

    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_pcwrite;
    logic               w_outvalid;
    logic               w_push;
    logic               w_pop;
    fq_entry_t          w_wr_entry;
    fq_entry_t          w_rd_entry;
    logic [31:0]        w_out_pc;

    // Space and validity come only from the registered count, so PCWrite has
    // no combinational path from the decode-side or flush inputs.
    assign w_pcwrite  = (r_count < c_full);
    assign w_outvalid = (r_count != '0);
    assign w_push     = fq.InValid && w_pcwrite && !fq.Flush;
    assign w_pop      = w_outvalid && !fq.DecodeStall && !fq.Flush;

    assign w_wr_entry.pc    = fq.InPC;
    assign w_wr_entry.instr = fq.InInstr;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_fq_entry_w)
    ) u_ram (
        .Clk     (Clk),
        .i_we    (w_push && !Reset),
        .i_waddr (r_wptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge Clk) begin
        if (Reset || fq.Flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_out_pc      = w_outvalid ? w_rd_entry.pc : 32'h0;
    assign fq.OutPC      = w_out_pc;
    assign fq.OutInstr   = w_outvalid ? w_rd_entry.instr : NOP_INSTR;
    assign fq.OutPCPlus4 = w_out_pc + 32'd4;
    assign fq.OutValid   = w_outvalid;
    assign fq.PCWrite    = w_pcwrite;
    assign fq.Count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Directed self-checking bench for fetch_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          c_depth = 4;
    localparam logic [31:0] c_nop   = 32'h00000013;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_queue_if #(.DEPTH(c_depth)) fq ();

    fetch_queue #(
        .DEPTH     (c_depth),
        .NOP_INSTR (c_nop)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .fq    (fq)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A0000;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_pc(input logic [31:0] pc);
        fq.InValid = 1'b1;
        fq.InPC    = pc;
        fq.InInstr = instr_of(pc);
        tick();
        fq.InValid = 1'b0;
    endtask

    initial begin
        fq.InPC        = '0;
        fq.InInstr     = '0;
        fq.InValid     = 1'b0;
        fq.Flush       = 1'b0;
        fq.DecodeStall = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        check("rst_count",  32'(fq.Count),   32'd0);
        check("rst_valid",  32'(fq.OutValid), 32'd0);
        check("rst_pc",     fq.OutPC,        32'h0);
        check("rst_instr",  fq.OutInstr,     c_nop);
        check("rst_pc4",    fq.OutPCPlus4,   32'h4);
        check("rst_pcwr",   32'(fq.PCWrite), 32'd1);

        // Three pushes under stall; the first must not bypass to the outputs
        fq.DecodeStall = 1'b1;
        fq.InValid     = 1'b1;
        fq.InPC        = 32'h0;
        fq.InInstr     = instr_of(32'h0);
        #1;
        check("nobypass_valid", 32'(fq.OutValid), 32'd0);
        tick();
        fq.InValid = 1'b0;
        check("lat1_valid", 32'(fq.OutValid), 32'd1);
        check("lat1_pc",    fq.OutPC,         32'h0);
        push_pc(32'h4);
        push_pc(32'h8);
        check("p3_count",  32'(fq.Count),   32'd3);
        check("p3_pc",     fq.OutPC,        32'h0);
        check("p3_instr",  fq.OutInstr,     instr_of(32'h0));
        check("p3_pc4",    fq.OutPCPlus4,   32'h4);
        check("p3_pcwr",   32'(fq.PCWrite), 32'd1);

        // Fill, then an ignored fifth push, then drain in order
        push_pc(32'hC);
        check("full_count", 32'(fq.Count),   32'd4);
        check("full_pcwr",  32'(fq.PCWrite), 32'd0);
        push_pc(32'h10);
        check("ovf_count",  32'(fq.Count),   32'd4);
        check("ovf_head",   fq.OutPC,        32'h0);
        fq.DecodeStall = 1'b0;
        #1;
        check("drain_pc0", fq.OutPC, 32'h0);
        tick();
        check("drain_pc1", fq.OutPC, 32'h4);
        check("drain_cnt1", 32'(fq.Count), 32'd3);
        tick();
        check("drain_pc2", fq.OutPC, 32'h8);
        tick();
        check("drain_pc3",    fq.OutPC,    32'hC);
        check("drain_instr3", fq.OutInstr, instr_of(32'hC));
        tick();
        check("drain_cnt0",  32'(fq.Count),    32'd0);
        check("drain_valid", 32'(fq.OutValid), 32'd0);
        check("drain_nop",   fq.OutInstr,      c_nop);

        // Full queue: simultaneous pop and attempted push
        fq.DecodeStall = 1'b1;
        push_pc(32'h20);
        push_pc(32'h24);
        push_pc(32'h28);
        push_pc(32'h2C);
        fq.DecodeStall = 1'b0;
        fq.InValid     = 1'b1;
        fq.InPC        = 32'h30;
        fq.InInstr     = instr_of(32'h30);
        tick();
        fq.InValid = 1'b0;
        check("fpp_count", 32'(fq.Count),   32'd3);
        check("fpp_pcwr",  32'(fq.PCWrite), 32'd1);
        check("fpp_head",  fq.OutPC,        32'h24);
        tick();
        tick();
        check("fpp_last",  fq.OutPC,        32'h2C);
        check("fpp_cnt1",  32'(fq.Count),   32'd1);
        tick();
        check("fpp_empty", 32'(fq.OutValid), 32'd0);

        // Flush overrides push and pop
        fq.DecodeStall = 1'b1;
        push_pc(32'h40);
        push_pc(32'h44);
        check("fl_pre_count", 32'(fq.Count), 32'd2);
        fq.Flush       = 1'b1;
        fq.DecodeStall = 1'b0;
        fq.InValid     = 1'b1;
        fq.InPC        = 32'h48;
        fq.InInstr     = instr_of(32'h48);
        tick();
        fq.Flush   = 1'b0;
        fq.InValid = 1'b0;
        check("fl_count", 32'(fq.Count),    32'd0);
        check("fl_valid", 32'(fq.OutValid), 32'd0);
        check("fl_instr", fq.OutInstr,      c_nop);
        check("fl_pc4",   fq.OutPCPlus4,    32'h4);
        fq.DecodeStall = 1'b1;
        push_pc(32'h50);
        check("fl_after_pc",  fq.OutPC,      32'h50);
        check("fl_after_cnt", 32'(fq.Count), 32'd1);

        // PC+4 wrap
        fq.DecodeStall = 1'b0;
        tick();
        fq.DecodeStall = 1'b1;
        push_pc(32'hFFFFFFFC);
        check("wrap_pc",  fq.OutPC,      32'hFFFFFFFC);
        check("wrap_pc4", fq.OutPCPlus4, 32'h00000000);

        // Reset mid-operation, with a push attempted during reset
        push_pc(32'h60);
        push_pc(32'h64);
        check("mr_pre_count", 32'(fq.Count), 32'd3);
        Reset      = 1'b1;
        fq.InValid = 1'b1;
        fq.InPC    = 32'h200;
        fq.InInstr = instr_of(32'h200);
        tick();
        Reset      = 1'b0;
        fq.InValid = 1'b0;
        check("mr_count", 32'(fq.Count),    32'd0);
        check("mr_pcwr",  32'(fq.PCWrite),  32'd1);
        check("mr_valid", 32'(fq.OutValid), 32'd0);
        push_pc(32'h100);
        check("mr_head_pc",    fq.OutPC,      32'h100);
        check("mr_head_instr", fq.OutInstr,   instr_of(32'h100));
        check("mr_head_cnt",   32'(fq.Count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
